ccsds_turbo_dec_source_pp: RTL and testbench
============================================

// Module: ccsds_turbo_dec_source_pp
// PURPOSE
//  Successor input stage of the CCSDS turbo decoder: accepts pLLR_N LLRs per beat, regroups them per code rate
//  (1/2, 1/3, 1/4, 1/6) into S/A0/A1 duobit words and writes them to an internal-managed ping-pong pair of
//  input RAM banks. Owns bank full/free tracking (no external ifulla/iemptya), checks frame length against
//  ilen and flags malformed frames. Sits between the demapper LLR stream and the input buffer RAMs.
// PARAMETERS
//  pLLR_W   5  LLR width
//  pLLR_FP  2  LLR fractional bits (passed to bit_llr_t)
//  pADDR_W  8  bank address width (symbols per frame <= 2**pADDR_W)
//  pLLR_N   1  LLRs per input beat, legal 1 or 2
//  pTAG_W   2  frame tag width
// PORTS
//  iclk      in   1           clock
//  ireset_n  in   1           asynchronous reset, active low
//  iclkena   in   1           clock enable; low freezes all state
//  icode     in   2           code rate (cCODE_*), sampled on ival&isop
//  ilen      in   pADDR_W     expected symbols-1, sampled on ival&isop
//  itag      in   pTAG_W      frame tag, sampled on ival&isop
//  isop/ieop in   1           frame start/end, qualified by ival
//  ival      in   1           beat valid
//  iLLR      in   pLLR_N*LLR  iLLR[0] earliest in stream
//  irelease  in   1           decoder frees the oldest full bank (pulse)
//  ordy      out  1           write bank free, may start a frame
//  obusy     out  1           any bank full or frame in progress
//  owrite    out  1           RAM write strobe
//  owbank    out  1           target bank
//  owaddr    out  pADDR_W     symbol address
//  osLLR     out  LLR         systematic
//  oa0LLR    out  LLR x3      encoder-0 parities
//  oa1LLR    out  LLR x3      encoder-1 parities, [1] tied '0
//  owdone    out  1           pulse: frame complete, bank marked full
//  owtag     out  pTAG_W      tag of the frame, valid with owdone
//  oerr      out  2           with owdone: [0] length mismatch, [1] partial group at eop
// BEHAVIOUR
//  - Reset: all outputs 0, both banks free, wbank=rbank=0, ordy=1 after reset release.
//  - Group length n = 2/3/4/6 for 1/2,1/3,1/4,1/6. Shift register depth 6+pLLR_N-1; fill counter cnt+=pLLR_N per
//    beat; when cnt>=n one group is emitted, cnt-=n (n>=pLLR_N => at most one group per beat). Group taken at
//    offset cnt+pLLR_N-n. isop beat restarts cnt (beat content counted), address 0, clears error flags.
//  - Mapping (group order g0..): 1/2 S=g0, even addr A0[0]=g1 else A1[0]=g1; 1/3 S,A0[0],A1[0];
//    1/4 S,A0[1],A0[2],A1[0]; 1/6 S,A0[0],A0[1],A0[2],A1[0],A1[2]. Unused outputs driven 0.
//  - Latency: owrite 2 enabled cycles after the beat completing a group; owaddr 0 then +1 per write.
//  - owdone/owtag/oerr 2 cycles after ieop beat, coincident with its last owrite (if any). Same cycle:
//    full[wbank]<=1, wbank toggles. oerr[0]= (writes != ilen+1); oerr[1]= (cnt!=0 after eop beat).
//  - Address wraps mod 2**pADDR_W; overrun is reported only via oerr[0].
//  - irelease: full[rbank]<=0, rbank toggles; ignored if full[rbank]=0. Simultaneous owdone and irelease on
//    different banks both apply; same bank impossible by construction.
//  - ordy = !full[wbank] registered; ival&isop with ordy=0 dropped entirely; beats outside a frame dropped.
//    Frame in progress continues regardless of ordy. isop mid-frame: abandon old frame, no owdone.
//  - Reset asserted mid-frame: frame discarded, banks freed.
// STRUCTURE
//  - ccsds_turbo_dec_types: bit_llr_t, cCODE_1by2/1by3/1by4/1by6, function get_code_len(code)->2..6.
//  - Sub-module ccsds_turbo_dec_source_bank_ctrl: full[2], wbank, rbank, ordy, owdone bank commit/release.
//  - Top: shift register + fill counter + mapping mux + length/error tracking.
// TESTING
//  - N=1, 1/3, ilen=3, LLR 1..12 -> 4 writes addr 0..3, S=1,4,7,10 A0[0]=2,5.. A1[0]=3,6..; owdone, oerr=0.
//  - N=2, 1/3, ilen=1, beats {1,2},{3,4},{5,6} -> writes (1,2,3),(4,5,6), second on beat 3 +2 cycles.
//  - 1/2, LLR 1..6 -> addr0 A0[0]=2, addr1 A1[0]=4, addr2 A0[0]=6, others 0.
//  - Two frames w/o irelease -> ordy=0, third isop dropped; irelease -> ordy=1 next cycle, wbank=0.
//  - 1/4 ilen=1 with 7 LLRs -> oerr=2'b11; ival&isop mid-frame -> no owdone for first frame.
//  - ireset_n low mid-frame -> outputs 0, ordy=1; iclkena low 5 cycles mid-frame -> output stream unchanged.

Source files
------------

// File: rtl/ccsds_turbo_dec_source_pp_pkg.sv
// ccsds_turbo_dec_source_pp_pkg: code-rate encodings and group-length helper for the turbo decoder input stage
package ccsds_turbo_dec_source_pp_pkg;
   typedef enum logic [1:0] {
      cCODE_1by2 = 2'd0,
      cCODE_1by3 = 2'd1,
      cCODE_1by4 = 2'd2,
      cCODE_1by6 = 2'd3
   } code_t;
   function automatic logic [2:0] get_code_len(input logic [1:0] code);
      return (code == cCODE_1by2) ? 3'd2 : (code == cCODE_1by3) ? 3'd3 : (code == cCODE_1by4) ? 3'd4 : 3'd6;
   endfunction
endpackage

// File: rtl/ccsds_turbo_dec_source_pp_if.sv
// ccsds_turbo_dec_source_pp_if: LLR input stream, bank release and RAM write bus of the input stage
interface ccsds_turbo_dec_source_pp_if #(parameter int pLLR_W = 5, pADDR_W = 8, pLLR_N = 1, pTAG_W = 2);
   logic                          iclkena, isop, ieop, ival, irelease;
   logic [1:0]                    icode;
   logic [pADDR_W-1:0]            ilen;
   logic [pTAG_W-1:0]             itag;
   logic [pLLR_N-1:0][pLLR_W-1:0] iLLR;
   logic                          ordy, obusy, owrite, owbank, owdone;
   logic [pADDR_W-1:0]            owaddr;
   logic [pLLR_W-1:0]             osLLR;
   logic [2:0][pLLR_W-1:0]        oa0LLR, oa1LLR;
   logic [pTAG_W-1:0]             owtag;
   logic [1:0]                    oerr;
   modport slave (input iclkena, isop, ieop, ival, irelease, icode, ilen, itag, iLLR,
                  output ordy, obusy, owrite, owbank, owdone, owaddr, osLLR, oa0LLR, oa1LLR, owtag, oerr);
   modport master (output iclkena, isop, ieop, ival, irelease, icode, ilen, itag, iLLR,
                   input ordy, obusy, owrite, owbank, owdone, owaddr, osLLR, oa0LLR, oa1LLR, owtag, oerr);
endinterface

// File: rtl/ccsds_turbo_dec_source_pp_bank_ctrl.sv
// ccsds_turbo_dec_source_pp_bank_ctrl: ping-pong bank full/free tracking with write/read bank pointers
module ccsds_turbo_dec_source_pp_bank_ctrl (
   input  logic iclk,
   input  logic ireset_n,
   input  logic iclkena,
   input  logic icommit,
   input  logic irelease,
   output logic owbank,
   output logic ordy,
   output logic ofull
);
   logic [1:0] r_full, w_full;
   logic       r_wbank, r_rbank, w_rel, w_wbank;
   assign w_rel   = irelease & r_full[r_rbank];
   assign w_wbank = r_wbank ^ icommit;
   assign owbank  = r_wbank;
   assign ofull   = |r_full;
   // next full flags: commit marks the write bank, release frees the read bank (never the same bank)
   always_comb begin
      w_full = r_full;
      if (icommit) w_full[r_wbank] = 1'b1;
      if (w_rel) w_full[r_rbank] = 1'b0;
   end
   // bank state and registered ready
   always_ff @(posedge iclk or negedge ireset_n)
      if (!ireset_n) begin
         r_full  <= '0;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         ordy    <= 1'b0;
      end else if (iclkena) begin
         r_full  <= w_full;
         r_wbank <= w_wbank;
         r_rbank <= r_rbank ^ w_rel;
         ordy    <= !w_full[w_wbank];
      end
endmodule

// File: rtl/ccsds_turbo_dec_source_pp.sv
// ccsds_turbo_dec_source_pp: regroups LLR beats into S/A0/A1 duobit words and writes them to ping-pong banks
module ccsds_turbo_dec_source_pp
   import ccsds_turbo_dec_source_pp_pkg::*;
#(parameter int pLLR_W = 5, pLLR_FP = 2, pADDR_W = 8, pLLR_N = 1, pTAG_W = 2)
(
   input logic iclk,
   input logic ireset_n,
   ccsds_turbo_dec_source_pp_if.slave io
);
   typedef struct packed {
      logic [pLLR_W-pLLR_FP-1:0] i;
      logic [pLLR_FP-1:0]        f;
   } bit_llr_t;
   localparam int cDEPTH = 6 + pLLR_N - 1;
   localparam int cIW = $clog2(cDEPTH);
   bit_llr_t [cDEPTH-1:0] r_sr, w_sr;
   bit_llr_t [5:0]        w_g, r_s1_g;
   logic [3:0]            r_cnt, w_cnt, w_off, w_rem;
   logic [2:0]            w_n;
   logic [1:0]            r_code, w_code, r_s1_code, r_s1_err;
   logic [pADDR_W-1:0]    r_len, w_lenv, r_addr, w_abase, r_s1_addr;
   logic [pADDR_W:0]      r_wcnt, w_wb, w_wcnt;
   logic [pTAG_W-1:0]     r_tag, r_s1_tag;
   logic [pLLR_W-1:0]     w_s;
   logic [2:0][pLLR_W-1:0] w_a0, w_a1;
   logic r_inframe, w_acc, w_sop, w_emit, w_done, w_err0, r_s1_val, r_s1_done, w_wbank, w_ordy, w_full;
   assign w_acc   = io.ival & (io.isop ? w_ordy : r_inframe);
   assign w_sop   = w_acc & io.isop;
   assign w_done  = w_acc & io.ieop;
   assign w_code  = w_sop ? io.icode : r_code;
   assign w_lenv  = w_sop ? io.ilen : r_len;
   assign w_n     = get_code_len(w_code);
   assign w_cnt   = (w_sop ? 4'd0 : r_cnt) + 4'(pLLR_N);
   assign w_emit  = w_acc & (w_cnt >= {1'b0, w_n});
   assign w_off   = w_cnt - {1'b0, w_n};
   assign w_rem   = w_emit ? w_off : w_cnt;
   assign w_abase = w_sop ? '0 : r_addr;
   assign w_wb    = w_sop ? '0 : r_wcnt;
   assign w_wcnt  = w_wb + {{pADDR_W{1'b0}}, w_emit & ~(&w_wb)};
   assign w_err0  = w_wcnt != ({1'b0, w_lenv} + (pADDR_W+1)'(1));
   assign io.ordy  = w_ordy;
   assign io.obusy = w_full | r_inframe | r_s1_done;
   // shift in the beat (newest LLR at index 0) and pick the oldest complete group
   always_comb begin
      w_sr = r_sr << (pLLR_N * pLLR_W);
      for (int k = 0; k < pLLR_N; k++) w_sr[pLLR_N-1-k] = io.iLLR[k];
      for (int j = 0; j < 6; j++) w_g[j] = (3'(j) < w_n) ? w_sr[cIW'(w_off + {1'b0, w_n} - 4'(j + 1))] : '0;
   end
   // group-to-port mapping per code rate; 1/2 alternates its parity between A0 and A1 by address
   always_comb begin
      w_s     = r_s1_g[0];
      w_a0    = '0;
      w_a1    = '0;
      w_a0[0] = (r_s1_code == cCODE_1by2) ? (r_s1_addr[0] ? '0 : r_s1_g[1]) :
                (r_s1_code == cCODE_1by4) ? '0 : r_s1_g[1];
      w_a0[1] = (r_s1_code == cCODE_1by4) ? r_s1_g[1] : (r_s1_code == cCODE_1by6) ? r_s1_g[2] : '0;
      w_a0[2] = (r_s1_code == cCODE_1by4) ? r_s1_g[2] : (r_s1_code == cCODE_1by6) ? r_s1_g[3] : '0;
      w_a1[0] = (r_s1_code == cCODE_1by2) ? (r_s1_addr[0] ? r_s1_g[1] : '0) :
                (r_s1_code == cCODE_1by3) ? r_s1_g[2] : (r_s1_code == cCODE_1by4) ? r_s1_g[3] : r_s1_g[4];
      w_a1[2] = (r_s1_code == cCODE_1by6) ? r_s1_g[5] : '0;
   end
   // frame state: shift register, fill counter, address, write count and frame parameters
   always_ff @(posedge iclk or negedge ireset_n)
      if (!ireset_n) begin
         r_sr      <= '0;
         r_cnt     <= '0;
         r_code    <= '0;
         r_len     <= '0;
         r_tag     <= '0;
         r_addr    <= '0;
         r_wcnt    <= '0;
         r_inframe <= 1'b0;
      end else if (io.iclkena && w_acc) begin
         r_sr      <= w_sr;
         r_cnt     <= w_rem;
         r_code    <= w_code;
         r_len     <= w_lenv;
         r_tag     <= w_sop ? io.itag : r_tag;
         r_addr    <= w_abase + pADDR_W'(w_emit);
         r_wcnt    <= w_wcnt;
         r_inframe <= !io.ieop;
      end
   // stage 1: capture the emitted group and end-of-frame status, zeroed when idle
   always_ff @(posedge iclk or negedge ireset_n)
      if (!ireset_n) begin
         r_s1_val  <= 1'b0;
         r_s1_g    <= '0;
         r_s1_code <= '0;
         r_s1_addr <= '0;
         r_s1_done <= 1'b0;
         r_s1_tag  <= '0;
         r_s1_err  <= '0;
      end else if (io.iclkena) begin
         r_s1_val  <= w_emit;
         r_s1_g    <= w_emit ? w_g : '0;
         r_s1_code <= w_code;
         r_s1_addr <= w_emit ? w_abase : '0;
         r_s1_done <= w_done;
         r_s1_tag  <= w_done ? (w_sop ? io.itag : r_tag) : '0;
         r_s1_err  <= w_done ? {w_rem != 4'd0, w_err0} : 2'b00;
      end
   // stage 2: registered RAM write bus and frame completion
   always_ff @(posedge iclk or negedge ireset_n)
      if (!ireset_n) begin
         io.owrite <= 1'b0;
         io.owbank <= 1'b0;
         io.owaddr <= '0;
         io.osLLR  <= '0;
         io.oa0LLR <= '0;
         io.oa1LLR <= '0;
         io.owdone <= 1'b0;
         io.owtag  <= '0;
         io.oerr   <= '0;
      end else if (io.iclkena) begin
         io.owrite <= r_s1_val;
         io.owbank <= w_wbank;
         io.owaddr <= r_s1_addr;
         io.osLLR  <= w_s;
         io.oa0LLR <= w_a0;
         io.oa1LLR <= w_a1;
         io.owdone <= r_s1_done;
         io.owtag  <= r_s1_tag;
         io.oerr   <= r_s1_err;
      end
   ccsds_turbo_dec_source_pp_bank_ctrl u_bank (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (io.iclkena),
      .icommit  (r_s1_done),
      .irelease (io.irelease),
      .owbank   (w_wbank),
      .ordy     (w_ordy),
      .ofull    (w_full)
   );
endmodule

// File: tb/tb_ccsds_turbo_dec_source_pp.sv
// tb_ccsds_turbo_dec_source_pp: scoreboard bench for the turbo decoder input stage (N=1 and N=2 instances)
module tb_ccsds_turbo_dec_source_pp;
   typedef struct packed {
      logic bank; logic [7:0] addr; logic [4:0] s; logic [2:0][4:0] a0; logic [2:0][4:0] a1;
   } wr_t;
   typedef struct packed {logic bank; logic [1:0] tag; logic [1:0] err;} dn_t;
   logic clk = 0, rst_n = 0, ena_q = 0, eb = 0;
   int   npass = 0, ntotal = 0, nfail = 0, cyc = 0;
   wr_t  qa[$], qb[$], ew;
   dn_t  qd[$], ed;
   int   qbc[$];
   ccsds_turbo_dec_source_pp_if #(.pLLR_N(1)) a();
   ccsds_turbo_dec_source_pp_if #(.pLLR_N(2)) b();
   ccsds_turbo_dec_source_pp #(.pLLR_N(1)) dut_a (.iclk(clk), .ireset_n(rst_n), .io(a));
   ccsds_turbo_dec_source_pp #(.pLLR_N(2)) dut_b (.iclk(clk), .ireset_n(rst_n), .io(b));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      ena_q <= a.iclkena;
      cyc   <= cyc + 1;
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic wr_t mk(input int code, input int base, input int addr, input logic bank);
      wr_t w = '0;
      w.bank = bank; w.addr = 8'(addr); w.s = 5'(base);
      case (code)
         0: if (addr % 2 == 0) w.a0[0] = 5'(base + 1); else w.a1[0] = 5'(base + 1);
         1: begin w.a0[0] = 5'(base + 1); w.a1[0] = 5'(base + 2); end
         2: begin w.a0[1] = 5'(base + 1); w.a0[2] = 5'(base + 2); w.a1[0] = 5'(base + 3); end
         default: begin
            w.a0[0] = 5'(base + 1); w.a0[1] = 5'(base + 2); w.a0[2] = 5'(base + 3);
            w.a1[0] = 5'(base + 4); w.a1[2] = 5'(base + 5);
         end
      endcase
      return w;
   endfunction
   // monitor A: writes and completions on enabled edges only
   always @(negedge clk) if (rst_n && ena_q) begin
      if (a.owrite) begin
         chk("a_write_expected", 64'(qa.size() != 0), 64'd1);
         if (qa.size() != 0) begin
            ew = qa.pop_front();
            chk("a_write", {a.owbank, a.owaddr, a.osLLR, a.oa0LLR, a.oa1LLR}, ew);
         end
      end
      if (a.owdone) begin
         chk("a_done_expected", 64'(qd.size() != 0), 64'd1);
         if (qd.size() != 0) begin
            ed = qd.pop_front();
            chk("a_done", {a.owbank, a.owtag, a.oerr}, ed);
         end
      end
   end
   // monitor B: data, latency and done coincident with the last write
   always @(negedge clk) if (rst_n && b.owrite) begin
      chk("b_write_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
         chk("b_write", {b.owbank, b.owaddr, b.osLLR, b.oa0LLR, b.oa1LLR}, qb.pop_front());
         chk("b_latency", 64'(cyc), 64'(qbc.pop_front()));
         chk("b_done", {b.owdone, b.owtag, b.oerr}, {qb.size() == 0, (qb.size() == 0) ? 2'd1 : 2'd0, 2'b00});
      end
   end
   task automatic send(input int code, len, tag, first, n, input bit eop, expect_ok, input int stall);
      int gl = (code == 0) ? 2 : (code == 1) ? 3 : (code == 2) ? 4 : 6;
      if (expect_ok) begin
         for (int k = 0; k < n / gl; k++) qa.push_back(mk(code, first + k * gl, k, eb));
         if (eop) begin
            qd.push_back({eb, 2'(tag), n % gl != 0, n / gl != len + 1});
            eb = ~eb;
         end
      end
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == stall) begin
            a.iclkena = 0;
            repeat (5) @(posedge clk);
            #1 a.iclkena = 1;
         end
         a.ival = 1; a.isop = (i == 0); a.ieop = eop && (i == n - 1);
         a.iLLR[0] = 5'(first + i); a.icode = 2'(code); a.ilen = 8'(len); a.itag = 2'(tag);
      end
      @(posedge clk); #1;
      a.ival = 0; a.isop = 0; a.ieop = 0;
   endtask
   task automatic drain();
      for (int i = 0; i < 60 && (qa.size() + qd.size() + qb.size()) != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain", 64'(qa.size() + qd.size() + qb.size()), 64'd0);
   endtask
   task automatic rel();
      @(posedge clk); #1 a.irelease = 1;
      @(posedge clk); #1 a.irelease = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      {a.ival, a.isop, a.ieop, a.irelease, a.icode, a.ilen, a.itag, a.iLLR} = '0;
      {b.ival, b.isop, b.ieop, b.irelease, b.icode, b.ilen, b.itag, b.iLLR} = '0;
      a.iclkena = 1; b.iclkena = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ordy", a.ordy, 0);
      chk("rst_outs", {a.owrite, a.owdone, a.oerr, a.obusy, a.owaddr}, 0);
      rst_n = 1;
      @(posedge clk); #1;
      chk("ordy_after_rst", a.ordy, 1);
      chk("busy_after_rst", a.obusy, 0);
      send(1, 3, 1, 1, 12, 1, 1, -1); drain();
      chk("busy_full", a.obusy, 1);
      rel();
      chk("busy_released", a.obusy, 0);
      send(0, 2, 2, 1, 6, 1, 1, -1); drain(); rel();
      send(1, 0, 3, 1, 3, 1, 1, -1); drain();
      send(1, 0, 0, 4, 3, 1, 1, -1); drain();
      chk("ordy_both_full", a.ordy, 0);
      chk("busy_both_full", a.obusy, 1);
      send(1, 0, 1, 7, 3, 1, 0, -1);
      repeat (6) @(posedge clk);
      drain();
      chk("ordy_still_low", a.ordy, 0);
      rel();
      chk("ordy_after_release", a.ordy, 1);
      send(1, 0, 1, 10, 3, 1, 1, -1); drain();
      rel(); rel();
      chk("busy_all_free", a.obusy, 0);
      rel();
      chk("ordy_spurious_release", a.ordy, 1);
      send(2, 1, 2, 1, 7, 1, 1, -1); drain(); rel();
      send(1, 1, 3, 1, 3, 0, 1, -1);
      send(1, 0, 3, 7, 3, 1, 1, -1); drain(); rel();
      send(3, 1, 1, 1, 12, 1, 1, -1); drain(); rel();
      send(1, 3, 2, 1, 12, 1, 1, 5); drain(); rel();
      qb.push_back(mk(1, 1, 0, 0)); qb.push_back(mk(1, 4, 1, 0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         b.ival = 1; b.isop = (i == 0); b.ieop = (i == 2); b.icode = 1; b.ilen = 1; b.itag = 1;
         b.iLLR[0] = 5'(2 * i + 1); b.iLLR[1] = 5'(2 * i + 2);
         if (i > 0) qbc.push_back(cyc + 2);
      end
      @(posedge clk); #1 b.ival = 0;
      drain();
      send(1, 0, 0, 1, 3, 1, 1, -1); drain();
      send(1, 3, 1, 1, 2, 0, 0, -1);
      rst_n = 0;
      #1;
      chk("midrst_outs", {a.owrite, a.owdone, a.obusy, a.ordy, a.osLLR}, 0);
      @(posedge clk); #1 rst_n = 1;
      eb = 0;
      @(posedge clk); #1;
      chk("midrst_ordy", a.ordy, 1);
      chk("midrst_busy", a.obusy, 0);
      send(0, 0, 2, 1, 2, 1, 1, -1); drain();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
